// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver: FSM state encoding,
// scan-code prefix bytes and the clock glitch-filter length.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam int         PS2_FILTER_LEN   = 8;

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer plus a glitch filter for one PS/2 line: the output
// only follows the synchronized input after PS2_FILTER_LEN equal samples.
module ps2_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(PS2_FILTER_LEN);

  logic [1:0]       sync_q, sync_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    filt_d = filt_q;
    cnt_d  = '0;
    // cnt_q counts consecutive samples that disagree with the filtered level
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(PS2_FILTER_LEN - 1)) filt_d = sync_q[1];
      else                                     cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/ps2_recv.sv
// PS/2 device-to-host frame receiver with parity/stop checking and timeout.
// Optional `PS2_RECV_PREFIX_DECODE_EN folds E0/F0 prefixes into extended/released.
module ps2_recv
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       extended,
  output logic       released,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [11:0] TO_MAX = 12'(TIMEOUT_CYCLES);

  logic       clk_filt;
  logic [1:0] dsync_q, dsync_d;
  logic       clk_prev_q, clk_prev_d;
  ps2_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_ok_q, par_ok_d;
  logic [11:0] to_cnt_q, to_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       din, fall, timeout, accept, err;

  ps2_filter u_clk_filter (
    .clk   (clk_25mhz),
    .reset (reset),
    .din   (ps2_clk),
    .dout  (clk_filt)
  );

  assign din     = dsync_q[1];
  assign fall    = clk_prev_q & ~clk_filt;
  assign timeout = (state_q != ST_IDLE) && (to_cnt_q == TO_MAX);
  assign err     = perr_d | ferr_d;

  always_comb begin
    dsync_d    = {dsync_q[0], ps2_data};
    clk_prev_d = clk_filt;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_ok_d   = par_ok_q;
    to_cnt_d   = (state_q == ST_IDLE) ? 12'd0 : to_cnt_q + 12'd1;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    accept     = 1'b0;
    // Timeout wins over a fall landing in the same cycle
    if (timeout) begin
      state_d  = ST_IDLE;
      ferr_d   = 1'b1;
      to_cnt_d = 12'd0;
    end else if (fall) begin
      to_cnt_d = 12'd0;
      unique case (state_q)
        ST_IDLE: begin
          if (!din) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = ^{shift_q, din};
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!din)          ferr_d = 1'b1;
          else if (!par_ok_q) perr_d = 1'b1;
          else               accept = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      dsync_q    <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_ok_q   <= 1'b0;
      to_cnt_q   <= 12'd0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      dsync_q    <= dsync_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      to_cnt_q   <= to_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

`ifdef PS2_RECV_PREFIX_DECODE_EN
  logic ext_pend_q, ext_pend_d;
  logic rel_pend_q, rel_pend_d;
  logic ext_q, ext_d;
  logic rel_q, rel_d;

  always_comb begin
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    ext_d      = 1'b0;
    rel_d      = 1'b0;
    if (err) begin
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end else if (accept) begin
      if (shift_q == PS2_PREFIX_EXT) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == PS2_PREFIX_BREAK) begin
        rel_pend_d = 1'b1;
      end else begin
        valid_d    = 1'b1;
        data_d     = shift_q;
        ext_d      = ext_pend_q;
        rel_d      = rel_pend_q;
        ext_pend_d = 1'b0;
        rel_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      ext_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
    end else begin
      ext_pend_q <= ext_pend_d;
      rel_pend_q <= rel_pend_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
    end
  end

  assign extended = ext_q;
  assign released = rel_q;
`else
  always_comb begin
    valid_d = accept;
    data_d  = accept ? shift_q : data_q;
  end

  assign extended = 1'b0;
  assign released = 1'b0;
`endif

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_recv.sv
// Bench for ps2_recv: table-driven frames, timeout and reset-abort sequences,
// and random frames, all checked against an event-level reference model.
module tb_ps2_recv;

  logic       clk_25mhz = 1'b0;
  logic       reset     = 1'b1;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic [7:0] data;
  logic       valid, extended, released, parity_err, frame_err, busy;

  ps2_recv #(.TIMEOUT_CYCLES(4095)) dut (
    .clk_25mhz  (clk_25mhz),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (data),
    .valid      (valid),
    .extended   (extended),
    .released   (released),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int half     = 40;
  int last_fall = 0;

  always @(posedge clk_25mhz) cyc <= cyc + 1;

  // kind: 0 = valid, 1 = parity error, 2 = frame error
  typedef struct {
    int         kind;
    logic [7:0] d;
    logic       e;
    logic       r;
  } ev_t;

  typedef struct {
    logic [7:0] code;
    logic       pb;
    logic       sb;
    int         hp;
    string      name;
  } vec_t;

  ev_t  obs_q[$];
  ev_t  exp_q[$];
  logic m_ext = 1'b0;
  logic m_rel = 1'b0;

  always @(negedge clk_25mhz) begin
    if (!reset) begin
      if (valid)      obs_q.push_back('{kind: 0, d: data, e: extended, r: released});
      if (parity_err) obs_q.push_back('{kind: 1, d: 8'h00, e: 1'b0, r: 1'b0});
      if (frame_err)  obs_q.push_back('{kind: 2, d: 8'h00, e: 1'b0, r: 1'b0});
    end
  end

  initial begin
    #8000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_25mhz);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(half);
    ps2_clk = 1'b0;
    last_fall = cyc;
    wait_cyc(half);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic pb, input logic sb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ pb);
    send_bit(~sb);
    ps2_data = 1'b1;
    wait_cyc(200);
  endtask

  task automatic send_partial(input logic [7:0] code, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(code[i]);
    ps2_data = 1'b1;
  endtask

  // Reference model: one frame -> expected strobes, with prefix folding when enabled
  task automatic model_frame(input logic [7:0] code, input logic pb, input logic sb);
    ev_t ev;
    ev = '{kind: 0, d: 8'h00, e: 1'b0, r: 1'b0};
    if (sb) begin
      ev.kind = 2; exp_q.push_back(ev); m_ext = 1'b0; m_rel = 1'b0;
    end else if (pb) begin
      ev.kind = 1; exp_q.push_back(ev); m_ext = 1'b0; m_rel = 1'b0;
    end else begin
`ifdef PS2_RECV_PREFIX_DECODE_EN
      if (code == 8'hE0) m_ext = 1'b1;
      else if (code == 8'hF0) m_rel = 1'b1;
      else begin
        ev.d = code; ev.e = m_ext; ev.r = m_rel;
        exp_q.push_back(ev);
        m_ext = 1'b0; m_rel = 1'b0;
      end
`else
      ev.d = code;
      exp_q.push_back(ev);
`endif
    end
  endtask

  task automatic compare(input string name);
    chk({name, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({name, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      chk({name, "_data"}, obs_q[i].d, exp_q[i].d);
      chk({name, "_ext"},  obs_q[i].e, exp_q[i].e);
      chk({name, "_rel"},  obs_q[i].r, exp_q[i].r);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  vec_t vecs[12];

  initial begin
    int   delay;
    bit   found;
    int   r;
    logic [7:0] code;
    logic pb, sb;

    vecs[0]  = '{code: 8'h1C, pb: 1'b1, sb: 1'b0, hp: 40,   name: "perr_1c"};
    vecs[1]  = '{code: 8'h1C, pb: 1'b0, sb: 1'b0, hp: 1024, name: "basic_1c"};
    vecs[2]  = '{code: 8'hF0, pb: 1'b0, sb: 1'b0, hp: 40,   name: "brk_f0"};
    vecs[3]  = '{code: 8'h1C, pb: 1'b0, sb: 1'b0, hp: 40,   name: "brk_1c"};
    vecs[4]  = '{code: 8'hE0, pb: 1'b0, sb: 1'b0, hp: 40,   name: "ext_e0"};
    vecs[5]  = '{code: 8'hF0, pb: 1'b0, sb: 1'b0, hp: 40,   name: "ext_f0"};
    vecs[6]  = '{code: 8'h75, pb: 1'b0, sb: 1'b0, hp: 40,   name: "ext_75"};
    vecs[7]  = '{code: 8'h3A, pb: 1'b0, sb: 1'b1, hp: 40,   name: "stop_bad"};
    vecs[8]  = '{code: 8'h3A, pb: 1'b1, sb: 1'b1, hp: 40,   name: "stop_and_par_bad"};
    vecs[9]  = '{code: 8'hE0, pb: 1'b0, sb: 1'b0, hp: 40,   name: "clr_e0"};
    vecs[10] = '{code: 8'h12, pb: 1'b1, sb: 1'b0, hp: 40,   name: "clr_perr"};
    vecs[11] = '{code: 8'h75, pb: 1'b0, sb: 1'b0, hp: 40,   name: "clr_75"};

    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_extended", extended, 0);
    chk("rst_released", released, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    obs_q.delete();

    for (int i = 0; i < 12; i++) begin
      half = vecs[i].hp;
      send_frame(vecs[i].code, vecs[i].pb, vecs[i].sb);
      model_frame(vecs[i].code, vecs[i].pb, vecs[i].sb);
      compare(vecs[i].name);
      if (i == 0) chk("data_hold_after_perr", data, 8'h00);
    end
    half = 40;

    // Clock stalls after four data bits
    send_partial(8'h29, 4);
    chk("timeout_busy_mid", busy, 1);
    found = 1'b0;
    delay = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk_25mhz);
      if (frame_err) begin
        found = 1'b1;
        delay = cyc - last_fall;
        break;
      end
    end
    chk("timeout_seen", found, 1);
    checks++;
    if (!(delay >= 4095 && delay <= 4130)) begin
      failures++;
      $display("FAIL timeout_delay actual=%0d required=4095..4130", delay);
    end
    wait_cyc(20);
    chk("timeout_busy_after", busy, 0);
    exp_q.push_back('{kind: 2, d: 8'h00, e: 1'b0, r: 1'b0});
    m_ext = 1'b0; m_rel = 1'b0;
    compare("timeout");
    send_frame(8'h29, 1'b0, 1'b0);
    model_frame(8'h29, 1'b0, 1'b0);
    compare("after_timeout_29");

    // Reset mid-frame after the fifth data bit
    send_partial(8'hC3, 5);
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(4);
    reset = 1'b0;
    m_ext = 1'b0; m_rel = 1'b0;
    wait_cyc(200);
    chk("reset_abort_busy", busy, 0);
    compare("reset_abort");
    send_frame(8'h5A, 1'b0, 1'b0);
    model_frame(8'h5A, 1'b0, 1'b0);
    compare("after_reset_5a");

    for (int i = 0; i < 14; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      code = 8'hE0;
      else if (r == 1) code = 8'hF0;
      else             code = 8'($urandom);
      pb = ($urandom_range(0, 7) == 0);
      sb = ($urandom_range(0, 7) == 0);
      send_frame(code, pb, sb);
      model_frame(code, pb, sb);
      compare("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_recv.md
PS2_RECV -- requirements
Module: ps2_recv

Interface
REQ-001 The module SHALL have the parameter TIMEOUT_CYCLES, default 4095, meaning the idle-clock cycles allowed between falling edges inside a frame before the frame is aborted.
REQ-002 The module SHALL have the port clk_25mhz, input, 1 bit: the single clock.
REQ-003 The module SHALL have the port reset, input, 1 bit: synchronous active-high reset.
REQ-004 The module SHALL have the port ps2_clk, input, 1 bit: asynchronous PS/2 clock from the device.
REQ-005 The module SHALL have the port ps2_data, input, 1 bit: asynchronous PS/2 data from the device.
REQ-006 The module SHALL have the port data, output, 8 bits: last accepted scan code.
REQ-007 The module SHALL have the port valid, output, 1 bit: one-cycle strobe; data, extended and released are valid when it is high.
REQ-008 The module SHALL have the port extended, output, 1 bit: the code was preceded by an E0 prefix.
REQ-009 The module SHALL have the port released, output, 1 bit: the code was preceded by an F0 prefix.
REQ-010 The module SHALL have the port parity_err, output, 1 bit: one-cycle strobe for a bad odd parity.
REQ-011 The module SHALL have the port frame_err, output, 1 bit: one-cycle strobe for a bad stop bit or a timeout.
REQ-012 The module SHALL have the port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-013 Both inputs SHALL pass through a 2-flop synchronizer; the synchronized ps2_clk SHALL then pass a filter that changes state only after 8 consecutive equal samples.
REQ-014 A falling edge (fall) SHALL be a 1-to-0 transition of the filtered clock; the synchronized ps2_data SHALL be sampled in the cycle the fall is detected.
REQ-015 The FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on fall with data=0, the FSM SHALL go to DATA with bit counter 0; on fall with data=1, the FSM SHALL stay in IDLE with no error strobe.
REQ-017 DATA: each fall SHALL shift a bit in LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-018 PARITY: the sampled bit SHALL be checked so that XOR(8 data bits, parity bit)=1; the result SHALL be held and the FSM SHALL go to STOP.
REQ-019 STOP: with data=1 and good parity, the byte SHALL be accepted; with data=1 and bad parity, parity_err SHALL pulse; with data=0, frame_err SHALL pulse and take precedence over a parity error. The FSM SHALL then go to IDLE.
REQ-020 valid, parity_err and frame_err SHALL assert in the cycle after the fall at the stop bit, for exactly 1 cycle.
REQ-021 busy SHALL be 1 in DATA, PARITY and STOP.
REQ-022 In any non-IDLE state, a 12-bit counter SHALL be cleared on each fall; when it reaches TIMEOUT_CYCLES, frame_err SHALL pulse, the FSM SHALL go to IDLE and the partial byte SHALL be discarded.
REQ-023 data SHALL hold its value between valid strobes; extended and released SHALL be meaningful only while valid is high.
REQ-024 Any error SHALL clear the pending prefix flags (see Configuration).
REQ-025 A fall in the same cycle as the timeout SHALL count as a timeout.

Reset
REQ-026 reset SHALL put the FSM in IDLE, clear the bit counter, shift register, timeout counter and pending flags, and set the filter and synchronizers to 1.
REQ-027 After reset, data SHALL be 0x00 and valid, extended, released, parity_err, frame_err and busy SHALL be 0.
REQ-028 A reset asserted mid-frame SHALL abort the frame with no strobe; the next frame SHALL decode normally.

Configuration
REQ-029 With PS2_RECV_PREFIX_DECODE_EN defined, an accepted 0xE0 SHALL set ext_pending and an accepted 0xF0 SHALL set rel_pending, and neither SHALL raise valid.
REQ-030 With PS2_RECV_PREFIX_DECODE_EN defined, the next accepted non-prefix byte SHALL raise valid with extended=ext_pending and released=rel_pending, and both pending flags SHALL then clear.
REQ-031 With PS2_RECV_PREFIX_DECODE_EN undefined, every accepted byte, 0xE0 and 0xF0 included, SHALL raise valid, and extended and released SHALL be tied to 0.

Structure
REQ-032 A shared package ps2_pkg SHALL hold the FSM state typedef and the constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BREAK=8'hF0 and PS2_FILTER_LEN=8.
REQ-033 A sub-module ps2_filter SHALL contain the synchronizer and filter for one line and SHALL be instantiated for ps2_clk; ps2_data SHALL use a synchronizer only.

Verification
REQ-034 The bench SHALL drive the device at a half-period of 1024 cycles and frame 0x1C with parity 0 -> one valid with data=0x1C, extended=0, released=0, and no errors.
REQ-035 The bench SHALL send frames F0, 1C with the macro on -> a single valid with data=0x1C and released=1; with the macro off -> two valids, 0xF0 then 0x1C.
REQ-036 The bench SHALL send frames E0, F0, 75 (macro on) -> one valid with data=0x75, extended=1 and released=1.
REQ-037 The bench SHALL send 0x1C with parity 1 -> parity_err pulses once, valid stays 0, and data remains 0x00.
REQ-038 The bench SHALL stop the clock after 4 data bits -> frame_err pulses 4095 cycles after the last fall; a following frame 0x29 then decodes correctly.
REQ-039 The bench SHALL assert reset after the 5th bit and then send 0x5A -> no strobe during the aborted frame, then one valid with data=0x5A.
